// File: rtl/m_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m_store_buffer_pkg
//  Description : Shared DMOp encodings and byte-enable width used by the
//                M-stage load extender and store buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package m_store_buffer_pkg;

   // Data-memory operation encodings shared with the load data extender
   localparam logic [2:0] DM_w  = 3'd0;
   localparam logic [2:0] DM_h  = 3'd1;
   localparam logic [2:0] DM_b  = 3'd2;
   localparam logic [2:0] DM_hu = 3'd3;
   localparam logic [2:0] DM_bu = 3'd4;

   // Byte-enable width of one bus word
   localparam int BE_W = 4;

endpackage : m_store_buffer_pkg
`default_nettype wire

// File: rtl/m_store_align.sv
`default_nettype none
// ============================================================================
//  Module      : m_store_align
//  Description : Turns a store (addr[1:0], GPR data, DMOp) into byte enables
//                and lane-replicated write data; flags misaligned and
//                illegal (non-store) DMOps.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_store_align
   import m_store_buffer_pkg::*;
(
   input  logic [1:0]      addr_lo_i,
   input  logic [31:0]     wdata_i,
   input  logic [2:0]      dmop_i,
   output logic [BE_W-1:0] be_o,
   output logic [31:0]     wdata_o,
   output logic            misalign_o,
   output logic            illegal_o
);

   // Decode the store width into lane enables, replicated data and legality
   always_comb begin
      be_o       = '0;
      wdata_o    = '0;
      misalign_o = 1'b0;
      illegal_o  = 1'b0;
      case (dmop_i)
         DM_w: begin
            be_o       = 4'b1111;
            wdata_o    = wdata_i;
            misalign_o = (addr_lo_i != 2'b00);
         end
         DM_h: begin
            be_o       = 4'b0011 << addr_lo_i;
            wdata_o    = {2{wdata_i[15:0]}};
            misalign_o = addr_lo_i[0];
         end
         DM_b: begin
            be_o       = 4'b0001 << addr_lo_i;
            wdata_o    = {4{wdata_i[7:0]}};
         end
         // Unsigned load variants are never valid for a store
         DM_hu, DM_bu: illegal_o = 1'b1;
         default:      illegal_o = 1'b1;
      endcase
   end

endmodule : m_store_align
`default_nettype wire

// File: rtl/m_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : m_store_buffer
//  Description : M-stage store buffer. Aligns CPU stores into word-aligned
//                bus writes, queues them in a small FIFO drained over a
//                valid/ready bus, raises store exceptions and reports
//                load-after-store word hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_store_buffer
   import m_store_buffer_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [2:0]        req_dmop,
   output logic              st_exc,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [BE_W-1:0]   bus_be,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_hit,
   output logic              empty
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam int               WA_W     = ADDR_W - 2;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // FIFO storage: word address, replicated data, byte enables, valid
   logic [WA_W-1:0]  waddr_q [DEPTH];
   logic [31:0]      data_q  [DEPTH];
   logic [BE_W-1:0]  be_q    [DEPTH];
   logic [DEPTH-1:0] vld_q;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   logic [BE_W-1:0]  w_be;
   logic [31:0]      w_wdata;
   logic             w_misalign;
   logic             w_illegal;
   logic             w_enq;
   logic             w_deq;
   logic [DEPTH-1:0] w_hit;
   logic             w_ld_lo_unused;

   m_store_align u_align (
      .addr_lo_i  (req_addr[1:0]),
      .wdata_i    (req_wdata),
      .dmop_i     (req_dmop),
      .be_o       (w_be),
      .wdata_o    (w_wdata),
      .misalign_o (w_misalign),
      .illegal_o  (w_illegal)
   );

   assign st_exc    = req_valid & (w_misalign | w_illegal);
   assign req_ready = (cnt_q != CNT_FULL);
   assign empty     = (cnt_q == '0);
   assign w_enq     = req_valid & req_ready & ~st_exc;
   assign w_deq     = bus_valid & bus_ready;

   // Bus side is driven purely from the registered head entry
   assign bus_valid = vld_q[rd_ptr_q];
   assign bus_addr  = {waddr_q[rd_ptr_q], 2'b00};
   assign bus_wdata = data_q[rd_ptr_q];
   assign bus_be    = be_q[rd_ptr_q];

   // Byte offset of the load does not matter for a word-granular hazard
   assign w_ld_lo_unused = ^ld_addr[1:0];

   // Per-entry word match against the load in M
   for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign w_hit[i] = vld_q[i] & (waddr_q[i] == ld_addr[ADDR_W-1:2]);
   end
   assign ld_hit = |w_hit;

   // Next-state for pointers and occupancy count
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (w_enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (w_deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (w_enq && !w_deq)      cnt_d = cnt_q + CNT_ONE;
      else if (w_deq && !w_enq) cnt_d = cnt_q - CNT_ONE;
   end

   // Pointer and count registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Entry storage: retire the head on a handshake, write the tail on accept.
   // Retired entries are zeroed so an empty FIFO presents an all-zero bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            waddr_q[i] <= '0;
            data_q[i]  <= '0;
            be_q[i]    <= '0;
         end
         vld_q <= '0;
      end else begin
         if (w_deq) begin
            vld_q[rd_ptr_q]   <= 1'b0;
            waddr_q[rd_ptr_q] <= '0;
            data_q[rd_ptr_q]  <= '0;
            be_q[rd_ptr_q]    <= '0;
         end
         if (w_enq) begin
            vld_q[wr_ptr_q]   <= 1'b1;
            waddr_q[wr_ptr_q] <= req_addr[ADDR_W-1:2];
            data_q[wr_ptr_q]  <= w_wdata;
            be_q[wr_ptr_q]    <= w_be;
         end
      end
   end

endmodule : m_store_buffer
`default_nettype wire

// File: tb/tb_m_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_store_buffer
//  Description : Directed self-checking bench for m_store_buffer with a
//                queue-based scoreboard of expected bus writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m_store_buffer;
   import m_store_buffer_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_dmop;
   logic        st_exc;
   logic        bus_valid;
   logic        bus_ready;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic        empty;

   always #5 clk = ~clk;

   m_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_dmop  (req_dmop),
      .st_exc    (st_exc),
      .bus_valid (bus_valid),
      .bus_ready (bus_ready),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_be    (bus_be),
      .ld_addr   (ld_addr),
      .ld_hit    (ld_hit),
      .empty     (empty)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } exp_t;

   exp_t sb[$];
   int   cnt_m  = 0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference store alignment
   function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] op, output logic legal,
                                 output logic [3:0] be, output logic [31:0] wd);
      legal = 1'b1; be = 4'b0000; wd = 32'h0;
      case (op)
         DM_w: begin legal = (a[1:0] == 2'b00); be = 4'b1111; wd = d; end
         DM_h: begin legal = ~a[0]; be = a[1] ? 4'b1100 : 4'b0011; wd = {d[15:0], d[15:0]}; end
         DM_b: begin
            wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
            case (a[1:0])
               2'd0: be = 4'b0001;
               2'd1: be = 4'b0010;
               2'd2: be = 4'b0100;
               default: be = 4'b1000;
            endcase
         end
         default: legal = 1'b0;
      endcase
   endfunction

   // Check all outputs for the inputs currently driven, update the
   // scoreboard, then advance one clock.
   task automatic cycle();
      logic        legal;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        hit;
      bit          enq, deq;
      #1;
      model(req_addr, req_wdata, req_dmop, legal, be, wd);
      chk("st_exc",    32'(st_exc),    32'(req_valid && !legal));
      chk("req_ready", 32'(req_ready), 32'(cnt_m < DEPTH));
      chk("empty",     32'(empty),     32'(cnt_m == 0));
      chk("bus_valid", 32'(bus_valid), 32'(cnt_m > 0));
      hit = 1'b0;
      foreach (sb[i]) if (sb[i].addr[31:2] == ld_addr[31:2]) hit = 1'b1;
      chk("ld_hit", 32'(ld_hit), 32'(hit));
      if (cnt_m > 0) begin
         chk("bus_addr",  bus_addr,      sb[0].addr);
         chk("bus_wdata", bus_wdata,     sb[0].data);
         chk("bus_be",    32'(bus_be),   32'(sb[0].be));
      end
      deq = bus_ready && (cnt_m > 0);
      enq = req_valid && legal && (cnt_m < DEPTH);
      if (deq) void'(sb.pop_front());
      if (enq) sb.push_back('{addr: {req_addr[31:2], 2'b00}, data: wd, be: be});
      cnt_m = cnt_m + int'(enq) - int'(deq);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
      req_valid = v;
      req_addr  = a;
      req_wdata = d;
      req_dmop  = op;
   endtask

   initial begin
      reset = 1'b1;
      bus_ready = 1'b0;
      ld_addr = 32'h0;
      drive(1'b0, 32'h0, 32'h0, DM_w);
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_bus_valid", 32'(bus_valid), 32'd0);
      chk("rst_bus_addr",  bus_addr,       32'd0);
      chk("rst_bus_wdata", bus_wdata,      32'd0);
      chk("rst_bus_be",    32'(bus_be),    32'd0);
      chk("rst_ld_hit",    32'(ld_hit),    32'd0);
      chk("rst_empty",     32'(empty),     32'd1);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      reset = 1'b0;

      // 1: sw, one-cycle latency, handshake, empty afterwards
      bus_ready = 1'b1;
      drive(1'b1, 32'h1000, 32'hDEADBEEF, DM_w); cycle();
      drive(1'b0, 32'h0, 32'h0, DM_w);           cycle();
      cycle();

      // 2: sb and sh lane replication
      drive(1'b1, 32'h1003, 32'h000000A5, DM_b); cycle();
      drive(1'b0, 32'h0, 32'h0, DM_w);           cycle();
      drive(1'b1, 32'h1002, 32'h00001234, DM_h); cycle();
      drive(1'b0, 32'h0, 32'h0, DM_w);           cycle();
      cycle();

      // 3: misaligned and illegal stores
      drive(1'b1, 32'h1002, 32'h11111111, DM_w);  cycle();
      drive(1'b1, 32'h1001, 32'h22222222, DM_h);  cycle();
      drive(1'b1, 32'h1000, 32'h33333333, DM_bu); cycle();
      drive(1'b1, 32'h1000, 32'h44444444, DM_hu); cycle();
      drive(1'b0, 32'h0, 32'h0, DM_w);            cycle();

      // 4: backpressure fills the FIFO, then drain in order
      bus_ready = 1'b0;
      drive(1'b1, 32'h3000, 32'h11111111, DM_w); cycle();
      drive(1'b1, 32'h3006, 32'h0000BEEF, DM_h); cycle();
      drive(1'b1, 32'h3009, 32'h0000005A, DM_b); cycle();
      cycle();
      bus_ready = 1'b1;
      cycle();
      cycle();
      drive(1'b0, 32'h0, 32'h0, DM_w);
      repeat (3) cycle();

      // 5: load-after-store hazard
      bus_ready = 1'b0;
      drive(1'b1, 32'h2001, 32'h00000077, DM_b); cycle();
      drive(1'b0, 32'h0, 32'h0, DM_w);
      ld_addr = 32'h2000; cycle();
      ld_addr = 32'h2004; cycle();
      ld_addr = 32'h2000; bus_ready = 1'b1; cycle();
      cycle();

      // 6: asynchronous reset with a full FIFO mid-handshake
      bus_ready = 1'b0;
      drive(1'b1, 32'h4000, 32'hCAFEF00D, DM_w); cycle();
      drive(1'b1, 32'h4004, 32'h0000ABCD, DM_h); cycle();
      drive(1'b0, 32'h0, 32'h0, DM_w);
      ld_addr = 32'h4000;
      bus_ready = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      chk("arst_bus_valid", 32'(bus_valid), 32'd0);
      chk("arst_empty",     32'(empty),     32'd1);
      chk("arst_req_ready", 32'(req_ready), 32'd1);
      chk("arst_ld_hit",    32'(ld_hit),    32'd0);
      sb.delete();
      cnt_m = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b1, 32'h5000, 32'h0BADC0DE, DM_w); cycle();
      drive(1'b0, 32'h0, 32'h0, DM_w);           cycle();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_m_store_buffer
`default_nettype wire
